uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_rx_os.sv | 158 +++++++++++++++
 tb/tb_uart_rx_os.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states, frame constants
// and the parity helper (parity pieces exist only when UART_RX_PARITY_EN is defined).
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks (16x bit rate).
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt_r;

  // Divider counter and registered tick
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= 16'd0;
      tick      <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= 16'd0;
      tick      <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + 16'd1;
      tick      <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with a one-entry holding register (8N1 by default;
// define UART_RX_PARITY_EN for 8E1 with a parity_err pulse).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID   = 4'(MID_SAMPLE);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic       tick_s;
  logic       rx_meta_r;
  logic       rx_sync_r;
  rx_state_t  state_r;
  logic [3:0] os_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       frame_err_r;
  logic       overrun_r;
  logic       parity_ok_s;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit_r;
  logic parity_err_r;
  assign parity_ok_s = (par_bit_r == even_parity(shift_r));
  assign parity_err  = parity_err_r;
`else
  assign parity_ok_s = 1'b1;
  assign parity_err  = 1'b0;
`endif

  // Receive FSM, holding register and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      os_cnt_r    <= 4'd0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!rx_sync_r) begin
              os_cnt_r <= 4'd0;
              state_r  <= ST_START;
            end
          end
          ST_START: begin
            os_cnt_r <= os_cnt_r + 4'd1;
            if (os_cnt_r == OS_MID) begin
              os_cnt_r <= 4'd0;
              state_r  <= rx_sync_r ? ST_IDLE : ST_DATA;
            end
          end
          ST_DATA: begin
            // Counter wraps 15->0 on its own, keeping each sample at mid-bit
            os_cnt_r <= os_cnt_r + 4'd1;
            if (os_cnt_r == OS_LAST) begin
              shift_r   <= {rx_sync_r, shift_r[7:1]};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_r <= ST_PARITY;
`else
                state_r <= ST_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            os_cnt_r <= os_cnt_r + 4'd1;
            if (os_cnt_r == OS_LAST) begin
              par_bit_r <= rx_sync_r;
              state_r   <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            os_cnt_r <= os_cnt_r + 4'd1;
            if (os_cnt_r == OS_LAST) begin
              state_r     <= ST_IDLE;
              frame_err_r <= !rx_sync_r;
`ifdef UART_RX_PARITY_EN
              parity_err_r <= !parity_ok_s;
`endif
              if (rx_sync_r && parity_ok_s) begin
                // A same-cycle handshake frees the register, so the load wins
                if (rx_valid_r && !rx_ready) begin
                  overrun_r <= 1'b1;
                end else begin
                  rx_data_r  <= shift_r;
                  rx_valid_r <= 1'b1;
                end
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at CLK_DIV=4 (64 clk per bit); parity case runs only
// when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  int valid_rise = 0;
  int hs_cnt = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  int perr_cycles = 0;
  logic prev_valid = 1'b0;

  int v0, h0, f0, o0, p0;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_os #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_rx(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_rx(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    drive_rx((^d) ^ par_flip, BIT_CLKS);
`endif
    drive_rx(stop_bit, BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic snap();
    v0 = valid_rise;
    h0 = hs_cnt;
    f0 = ferr_cycles;
    o0 = ovr_cycles;
    p0 = perr_cycles;
  endtask

  // Output monitor: pulse counters and scoreboard pop on each handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_valid && !prev_valid) valid_rise++;
        if (rx_valid && rx_ready) begin
          hs_cnt++;
          chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        ferr_cycles += int'(frame_err);
        ovr_cycles  += int'(overrun);
        perr_cycles += int'(parity_err);
      end
      prev_valid = rx_valid;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    rst = 1'b0;
    drive_rx(1'b1, BIT_CLKS);

    // Single good byte with consumer ready
    rx_ready = 1'b1;
    snap();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    drive_rx(1'b1, BIT_CLKS);
    chk("t1_valid_pulses", 32'(valid_rise - v0), 32'd1);
    chk("t1_handshakes", 32'(hs_cnt - h0), 32'd1);
    chk("t1_ferr", 32'(ferr_cycles - f0), 32'd0);
    chk("t1_ovr", 32'(ovr_cycles - o0), 32'd0);
    chk("t1_perr", 32'(perr_cycles - p0), 32'd0);

    // Back-to-back bytes with consumer stalled: overrun, first byte retained
    rx_ready = 1'b0;
    snap();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    drive_rx(1'b1, BIT_CLKS);
    chk("t2_valid_held", 32'(rx_valid), 32'd1);
    chk("t2_data_held", 32'(rx_data), 32'hA3);
    chk("t2_ovr", 32'(ovr_cycles - o0), 32'd1);
    chk("t2_valid_rises", 32'(valid_rise - v0), 32'd1);
    exp_q.push_back(8'hA3);
    rx_ready = 1'b1;
    drive_rx(1'b1, 3);
    chk("t2_valid_clear", 32'(rx_valid), 32'd0);
    chk("t2_handshakes", 32'(hs_cnt - h0), 32'd1);

    // Bad stop bit then a good byte
    snap();
    send_frame(8'hF0, 1'b0);
    drive_rx(1'b1, 2 * BIT_CLKS);
    chk("t3_ferr", 32'(ferr_cycles - f0), 32'd1);
    chk("t3_no_valid", 32'(valid_rise - v0), 32'd0);
    chk("t3_valid_low", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    drive_rx(1'b1, BIT_CLKS);
    chk("t3_next_valid", 32'(valid_rise - v0), 32'd1);
    chk("t3_ferr_once", 32'(ferr_cycles - f0), 32'd1);

    // Short low glitch on idle line is a false start
    snap();
    drive_rx(1'b0, 20);
    drive_rx(1'b1, 2 * BIT_CLKS);
    chk("t4_no_valid", 32'(valid_rise - v0), 32'd0);
    chk("t4_no_err", 32'(ferr_cycles - f0 + ovr_cycles - o0 + perr_cycles - p0), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drive_rx(1'b1, BIT_CLKS);
    chk("t4_valid", 32'(valid_rise - v0), 32'd1);

    // Reset pulse in the middle of bit 4 of 0x77
    snap();
    drive_rx(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_rx(1'(8'h77 >> i), BIT_CLKS);
    drive_rx(1'b1, BIT_CLKS / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_valid", 32'(rx_valid), 32'd0);
    chk("t5_data", 32'(rx_data), 32'h00);
    chk("t5_pulses", 32'({frame_err, overrun, parity_err}), 32'd0);
    drive_rx(1'b1, 2 * BIT_CLKS);
    chk("t5_no_valid", 32'(valid_rise - v0), 32'd0);
    chk("t5_no_err", 32'(ferr_cycles - f0 + ovr_cycles - o0 + perr_cycles - p0), 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    drive_rx(1'b1, BIT_CLKS);
    chk("t5_valid_after", 32'(valid_rise - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // Wrong parity discards, correct parity delivers
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    drive_rx(1'b1, BIT_CLKS);
    chk("t6_perr", 32'(perr_cycles - p0), 32'd1);
    chk("t6_no_valid", 32'(valid_rise - v0), 32'd0);
    par_flip = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1);
    drive_rx(1'b1, BIT_CLKS);
    chk("t6_valid", 32'(valid_rise - v0), 32'd1);
    chk("t6_perr_once", 32'(perr_cycles - p0), 32'd1);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
